ifetch_buffer: RTL and testbench

Instruction-fetch stage for the pipelined core. It sits directly upstream of decode and drives the address port of `InstrMem`, which is a combinational word read. Each cycle it fetches one instruction at a sequential PC into a small prefetch FIFO. It presents the oldest entry to decode with a valid/ready handshake and flushes on a redirect from branch/jump resolution.

---
 rtl/ifb_pkg.sv | 15 +
 rtl/ifb_fifo.sv | 70 +++++++
 rtl/ifetch_buffer.sv | 106 ++++++++++
 tb/tb_ifetch_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// ifb_pkg -- shared types and constants for the instruction-fetch buffer.
//   fetch_entry_t   : one prefetched instruction, packed {pc, instr}
//   IFB_INSTR_BYTES : fetch stride in bytes (one 32-bit instruction)
//   IFB_RESET_PC    : default fetch address after reset
package ifb_pkg;

    localparam int          IFB_INSTR_BYTES = 4;
    localparam logic [31:0] IFB_RESET_PC    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo -- synchronous FIFO of fetch_entry_t with flush and async reset.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   i_push     : write i_wdata at the write pointer
//   i_pop      : retire the entry at the read pointer
//   i_flush    : empty the FIFO (wins over push and pop)
//   i_wdata    : entry to write
//   o_rdata    : entry at the read pointer (don't-care when empty)
//   o_count    : number of valid entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_wdata,
    output fetch_entry_t           o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Guard against over/underflow locally; a push into a full FIFO is only
    // legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);
    assign w_do_push = i_push & ~i_flush & ((r_count != FULL_CNT) | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer -- instruction-fetch stage with a small prefetch FIFO.
// Fetches one word per cycle at a sequential PC from a combinational
// instruction memory and presents the oldest fetched entry to decode with a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   redirect_i      : flush and restart fetch at redirect_pc_i
//   redirect_pc_i   : new fetch PC (bits [1:0] ignored)
//   imem_addr_o     : current fetch PC, drives InstrMem
//   imem_instr_i    : instruction for imem_addr_o (same cycle)
//   valid_o/ready_i : decode handshake
//   instr_o, pc_o   : presented instruction and its PC
//   pc_plus4_o      : pc_o + 4 (mod 2^32)
// Build option: define IFB_BYPASS_EN to present the memory word directly to
// decode when the FIFO is empty (adds an imem_instr_i -> instr_o path).
module ifetch_buffer
    import ifb_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFB_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    fetch_entry_t  w_fetch_entry;
    fetch_entry_t  w_head;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_pop;
    logic          w_push;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_unused_pc_lsbs;

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == FULL_CNT);

`ifdef IFB_BYPASS_EN
    // Empty FIFO: show the word being fetched this cycle. Suppressed during
    // reset so valid_o reads 0 while rst is held.
    assign w_bypass = ~rst & w_empty & ~redirect_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign valid_o = ~w_empty | w_bypass;
    assign w_pop   = valid_o & ready_i;
    assign w_push  = ~redirect_i & (~w_full | w_pop);

    // A bypassed word accepted by decode is consumed without touching the
    // FIFO; the fetch PC still advances because w_push is set.
    assign w_bypass_take = w_bypass & ready_i;
    assign w_fifo_push   = w_push & ~w_bypass_take;
    assign w_fifo_pop    = w_pop & ~w_bypass & ~redirect_i;

    assign w_fetch_entry = '{pc: r_fetch_pc, instr: imem_instr_i};

    ifb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_flush (redirect_i),
        .i_wdata (w_fetch_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'(IFB_INSTR_BYTES);
        end
    end

    // Word alignment is forced; the low redirect bits carry no information.
    assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

    assign imem_addr_o = r_fetch_pc;
    assign instr_o     = w_bypass ? imem_instr_i : w_head.instr;
    assign pc_o        = w_bypass ? r_fetch_pc   : w_head.pc;
    assign pc_plus4_o  = pc_o + 32'(IFB_INSTR_BYTES);

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer -- scoreboard bench for ifetch_buffer (DEPTH = 4).
// Expected PCs are queued as each scenario is set up and popped whenever the
// DUT hands an entry to decode (valid_o & ready_i, no redirect).
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    // Instruction memory model: address-dependent word so stale data shows.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr_i = imem_word(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sample();
        logic [31:0] e;
        if (valid_o && ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pc", pc_o, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc_o, e);
                check("sb_instr", instr_o, imem_word(e));
                check("sb_pc_plus4", pc_plus4_o, e + 32'd4);
            end
        end
    endtask

    // One cycle: drive inputs at the falling edge, sample 1 time unit later.
    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        sample();
    endtask

    // Leaves the DUT in reset state with no edge after deassertion yet.
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        ready_i    = 1'b0;
        redirect_i = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc(1'b1, 1'b0, 32'h0);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Sequential fetch with decode always ready.
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        cyc(1'b1, 1'b0, 32'h0);
`ifdef IFB_BYPASS_EN
        check("seq_bypass_valid0", {31'b0, valid_o}, 32'd1);
`else
        check("seq_valid0", {31'b0, valid_o}, 32'd0);
`endif
        check("seq_addr0", imem_addr_o, 32'h0);
        for (int k = 1; k < 20 && exp_q.size() != 0; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            check("seq_addr", imem_addr_o, 32'(4 * k));
            check("seq_valid", {31'b0, valid_o}, 32'd1);
        end
        check("seq_drain", 32'(exp_q.size()), 32'd0);

        // Decode stalled: FIFO fills and fetch holds, then full pop+push.
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0);
        check("stall_addr_hold", imem_addr_o, 32'h10);
        check("stall_valid", {31'b0, valid_o}, 32'd1);
        check("stall_head_pc", pc_o, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        check("full_popush_addr", imem_addr_o, 32'h14);
        check("full_popush_head", pc_o, 32'h4);
        cyc(1'b0, 1'b0, 32'h0);
        check("full_still_full", imem_addr_o, 32'h14);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            cyc(1'b1, 1'b0, 32'h0);
            check("drain_no_gap", {31'b0, valid_o}, 32'd1);
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // Redirect with three entries queued and decode ready.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0000_0103);
        check("redir_presented", {31'b0, valid_o}, 32'd1);
        check("redir_head", pc_o, 32'h0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        cyc(1'b1, 1'b0, 32'h0);
        check("redir_addr", imem_addr_o, 32'h100);
`ifndef IFB_BYPASS_EN
        check("redir_valid_drop", {31'b0, valid_o}, 32'd0);
`endif
        drain("redir_drain", 10);

        // Redirect to the top of the address space: PC wraps to zero.
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        cyc(1'b1, 1'b0, 32'h0);
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        drain("wrap_drain", 10);

        // Asynchronous reset between edges with entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
        check("pre_arst_addr", imem_addr_o, 32'h8);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, valid_o}, 32'd0);
        check("arst_addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        cyc(1'b1, 1'b0, 32'h0);
`ifdef IFB_BYPASS_EN
        check("bypass_same_cycle_valid", {31'b0, valid_o}, 32'd1);
`else
        check("post_arst_valid", {31'b0, valid_o}, 32'd0);
`endif
        check("post_arst_addr", imem_addr_o, 32'h0);
        drain("post_arst_drain", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
